// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC rate/sequencing controller.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FILL  = 2'd2,
    RUN   = 2'd3
  } ctrl_state_e;

  localparam int unsigned CIC_RATE_W = 3;
  typedef logic [CIC_RATE_W-1:0] rate_t;

  // Legal log2(RATE) values are 1..max_rate; zero would mean no decimation at all.
  function automatic logic is_legal_rate(input int unsigned rate, input int unsigned max_rate);
    return (rate >= 32'd1) && (rate <= max_rate);
  endfunction

endpackage

// File: rtl/cic_rate_ctrl.sv
// Sequencing/config controller for the CIC datapath: clear -> fill -> run on every
// start or rate change, gating out_valid so transient samples never escape.
module cic_rate_ctrl
  import cic_pkg::*;
#(
  parameter int unsigned N_STAGES      = 3,
  parameter int unsigned MAX_LOG2_RATE = 4,
  parameter int unsigned DEF_LOG2_RATE = 2,
  parameter int unsigned CLR_CYCLES    = 2,
  parameter int unsigned RATE_W        = 3
) (
  input  logic              clk_slow,
  input  logic              rstn,
  input  logic              en,
  input  logic              cfg_req,
  input  logic [RATE_W-1:0] cfg_log2_rate,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [RATE_W-1:0] rate_log2,
  output logic              clear,
  output logic              out_valid,
  output logic              busy
);

  localparam int unsigned CNT_MAX = (CLR_CYCLES > N_STAGES + 1) ? CLR_CYCLES : N_STAGES + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] FILL_LOAD = CNT_W'(N_STAGES + 1);
  localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  ctrl_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              clear_q, clear_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              req_seen;
  logic              req_ok;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rate_d   = rate_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    // A request still high while its ack is showing is the one just consumed.
    req_seen = cfg_req && !ack_q;
    req_ok   = is_legal_rate(32'(cfg_log2_rate), MAX_LOG2_RATE);

    unique case (state_q)
      IDLE: begin
        if (req_seen) begin
          ack_d = 1'b1;
          if (req_ok) rate_d = cfg_log2_rate;
          else        err_d  = 1'b1;
        end else if (en) begin
          state_d = FILL;
          cnt_d   = FILL_LOAD;
        end
      end
      CLEAR: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = FILL;
          cnt_d   = FILL_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      FILL: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (req_seen) begin
          ack_d = 1'b1;
          if (req_ok) begin
            rate_d  = cfg_log2_rate;
            state_d = CLEAR;
            cnt_d   = CLR_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Status outputs are decoded from the next state so they register with it.
    clear_d = (state_d == IDLE) || (state_d == CLEAR);
    valid_d = (state_d == RUN);
    busy_d  = (state_d == CLEAR) || (state_d == FILL);
  end

  always_ff @(posedge clk_slow or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rate_q  <= RATE_W'(DEF_LOG2_RATE);
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      clear_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      clear_q <= clear_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign cfg_ack   = ack_q;
  assign cfg_err   = err_q;
  assign rate_log2 = rate_q;
  assign clear     = clear_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;

endmodule

// File: doc/cic_rate_ctrl.md
Name: cic_rate_ctrl

Overview:
Sequencing and configuration controller for the CIC decimation/interpolation datapath, running in the clk_slow domain. It owns the active rate setting (log2 of RATE) and accepts rate changes from a host over a req/ack handshake. On each start or rate change it runs the sequence clear → fill → run. It gates sample validity so downstream logic never consumes transient samples from integrators, combs, or the rate-change stage.

Parameters:
N_STAGES, 3, CIC order (integrator/comb pairs).
MAX_LOG2_RATE, 4, largest legal log2(RATE); legal range is 1..MAX_LOG2_RATE.
DEF_LOG2_RATE, 2, rate_log2 value after reset; must be within the legal range.
CLR_CYCLES, 2, clk_slow cycles that clear is held during a rate change.
RATE_W, 3, width of rate fields; must satisfy 2**RATE_W > MAX_LOG2_RATE.

Ports:
clk_slow  in  1  controller clock (slow/decimated domain)
rstn  in  1  asynchronous, active-low reset
en  in  1  filter enable (level)
cfg_req  in  1  rate-change request (level, held until cfg_ack)
cfg_log2_rate  in  RATE_W  requested log2(RATE), sampled while cfg_req is high
cfg_ack  out  1  one-cycle pulse: request consumed
cfg_err  out  1  one-cycle pulse coincident with cfg_ack: request rejected
rate_log2  out  RATE_W  active rate setting driven to the datapath
clear  out  1  synchronous clear to integrators/combs (active high)
out_valid  out  1  filter output samples are valid
busy  out  1  high in CLEAR or FILL

Behaviour:
- All outputs are registered.
- Reset (async): state IDLE, rate_log2=DEF_LOG2_RATE, clear=1, out_valid=0, cfg_ack=0, cfg_err=0, busy=0, counter=0. Reset asserted mid-operation has the same effect immediately.
- States: IDLE, CLEAR, FILL, RUN. Single down-counter, width $clog2(max(CLR_CYCLES, N_STAGES+1))+1.
- IDLE: clear=1, out_valid=0.
  - en=1 → FILL; counter loaded with N_STAGES+1; clear=0 after the edge.
- CLEAR: clear=1, busy=1, out_valid=0.
  - Counter loaded with CLR_CYCLES on entry.
  - At terminal count → FILL; counter loaded with N_STAGES+1.
- FILL: clear=0, busy=1, out_valid=0.
  - Counter decrements each cycle.
  - After N_STAGES+1 cycles → RUN; out_valid=1 is registered on the same edge.
- RUN: out_valid=1.
  - Legal cfg_req → CLEAR; rate_log2 updated on the same edge; cfg_ack=1 and out_valid=0 after that edge.
- Legality: 1 ≤ cfg_log2_rate ≤ MAX_LOG2_RATE.
  - Illegal request: cfg_ack=1 and cfg_err=1 for one cycle; state and rate_log2 unchanged; out_valid unaffected.
- Where requests are accepted:
  - IDLE: legal request updates rate_log2 and acks; state stays IDLE.
  - CLEAR/FILL: cfg_req is not acked; it stays pending until RUN.
- Back-to-back guard: cfg_req is ignored in any cycle where cfg_ack is already high.
- en=0 in any non-IDLE state → IDLE on the next edge (clear=1, out_valid=0). A simultaneous cfg_req is not acked that cycle; it is handled in IDLE on the following cycle.
- Priority: rstn > en=0 > cfg_req.
- Counter arithmetic is unsigned and never wraps; reloads occur only on state entry.

Decomposition:
- Package cic_pkg:
  - state enum ctrl_state_e {IDLE, CLEAR, FILL, RUN}
  - rate-width typedef
  - function is_legal_rate()
- No sub-module. FSM and counter live in one module; the generic counter is inline.

Test Plan:
- Reset, then en=1 sampled at edge k → clear=0 after k; out_valid=1 after edge k+4; busy=1 over k..k+3.
- In RUN, cfg_req=1, cfg_log2_rate=3 sampled at edge t → after t: cfg_ack=1, rate_log2=3, clear=1, out_valid=0; clear=0 after t+2; out_valid=1 after t+6; single ack pulse.
- In RUN, cfg_log2_rate=7 (and separately 0) → cfg_ack=cfg_err=1 for one cycle; rate_log2 stays 2; out_valid stays 1; no clear.
- cfg_req=1 (rate 1) asserted during FILL → no ack until RUN is reached; then accepted and the CLEAR/FILL sequence reruns.
- en dropped in FILL and in RUN with simultaneous cfg_req → IDLE next edge, clear=1, out_valid=0; request acked one cycle later with rate updated, state still IDLE.
- rstn pulsed low mid-CLEAR → all outputs take reset values asynchronously (rate_log2=2); on release with en=1, the full fill sequence restarts.
